// File: rtl/fp_div_seq_if.sv
// Handshake and operand/result bundle for the sequential single-precision divider.
//   start, n1, n2          : request and operands, driven by the requester (master)
//   busy, done             : progress and one-cycle completion pulse, driven by the divider (slave)
//   result, Overflow,
//   Underflow, Exception   : quotient and status flags, held until the next completion
interface fp_div_seq_if;
   logic        start;
   logic [31:0] n1;
   logic [31:0] n2;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic        Overflow;
   logic        Underflow;
   logic        Exception;

   modport master (
      output start, n1, n2,
      input  busy, done, result, Overflow, Underflow, Exception
   );

   modport slave (
      input  start, n1, n2,
      output busy, done, result, Overflow, Underflow, Exception
   );
endinterface

// File: rtl/fp_div_seq.sv
// Sequential IEEE-754 single-precision divider: result = n1 / n2.
// 25-step restoring mantissa division, truncating (no rounding), with
// Overflow / Underflow / Exception flags held alongside the result.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fp_div_seq_if.slave (start/n1/n2 in; busy/done/result/flags out)
module fp_div_seq (
   input  logic         clk,
   input  logic         rst_n,
   fp_div_seq_if.slave  bus
);

   localparam int unsigned MANT_W = 24;
   localparam int unsigned REM_W  = 26;
   localparam int unsigned QUO_W  = 25;
   localparam int unsigned EXP_W  = 10;
   localparam int unsigned CNT_W  = 5;
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(24);
   localparam logic [31:0]      QNAN      = 32'h7FC0_0000;

   typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;

   state_t              state;
   logic [CNT_W-1:0]    count;
   logic [REM_W-1:0]    rem;
   logic [QUO_W-1:0]    quo;
   logic [MANT_W-1:0]   mb;
   logic [7:0]          e1;
   logic [7:0]          e2;
   logic                sign;
   logic                special;

   // Staged outcome, published to the held outputs only on the DONE transition
   logic [31:0]         stage_result;
   logic                stage_ovf;
   logic                stage_unf;
   logic                stage_exc;

   logic                busy_q;
   logic                done_q;
   logic [31:0]         result_q;
   logic                ovf_q;
   logic                unf_q;
   logic                exc_q;

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.Overflow  = ovf_q;
   assign bus.Underflow = unf_q;
   assign bus.Exception = exc_q;

   // Operand fields seen on the accepting edge
   logic [7:0] in_e1;
   logic [7:0] in_e2;
   logic       in_sign;
   assign in_e1   = bus.n1[30:23];
   assign in_e2   = bus.n2[30:23];
   assign in_sign = bus.n1[31] ^ bus.n2[31];

   // One restoring step: subtract the divisor when it fits
   logic             q_bit;
   logic [REM_W-1:0] rem_sub;
   assign q_bit   = (rem >= REM_W'(mb));
   assign rem_sub = q_bit ? (rem - REM_W'(mb)) : rem;

   // Normalisation: quotient lies in [0.5, 2), so at most a one-bit adjust.
   // Exponent is formed modulo 2^10 and reinterpreted as signed.
   logic signed [EXP_W-1:0] exp_q;
   logic [22:0]             mant_q;
   assign exp_q  = signed'(EXP_W'(e1) - EXP_W'(e2)
                   + (quo[QUO_W-1] ? EXP_W'(127) : EXP_W'(126)));
   assign mant_q = quo[QUO_W-1] ? quo[23:1] : quo[22:0];

   // Control, datapath and held outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         count        <= '0;
         rem          <= '0;
         quo          <= '0;
         mb           <= '0;
         e1           <= '0;
         e2           <= '0;
         sign         <= 1'b0;
         special      <= 1'b0;
         stage_result <= '0;
         stage_ovf    <= 1'b0;
         stage_unf    <= 1'b0;
         stage_exc    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         result_q     <= '0;
         ovf_q        <= 1'b0;
         unf_q        <= 1'b0;
         exc_q        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // busy stays up through the done cycle; a start there is ignored
               if (done_q) begin
                  done_q <= 1'b0;
                  busy_q <= 1'b0;
               end else if (bus.start) begin
                  busy_q <= 1'b1;
                  count  <= '0;
                  e1     <= in_e1;
                  e2     <= in_e2;
                  sign   <= in_sign;
                  rem    <= REM_W'({|in_e1, bus.n1[22:0]});
                  mb     <= {|in_e2, bus.n2[22:0]};
                  quo    <= '0;
                  if (in_e1 == 8'hFF || in_e2 == 8'hFF || in_e2 == 8'h00) begin
                     special      <= 1'b1;
                     stage_result <= QNAN;
                     stage_ovf    <= 1'b0;
                     stage_unf    <= 1'b0;
                     stage_exc    <= 1'b1;
                     state        <= NORM;
                  end else if (in_e1 == 8'h00) begin
                     special      <= 1'b1;
                     stage_result <= {in_sign, 31'h0};
                     stage_ovf    <= 1'b0;
                     stage_unf    <= 1'b0;
                     stage_exc    <= 1'b0;
                     state        <= NORM;
                  end else begin
                     special <= 1'b0;
                     state   <= CALC;
                  end
               end
            end
            CALC: begin
               rem   <= rem_sub << 1;
               quo   <= {quo[QUO_W-2:0], q_bit};
               count <= count + CNT_W'(1);
               if (count == LAST_ITER) begin
                  state <= NORM;
               end
            end
            NORM: begin
               if (!special) begin
                  stage_exc <= 1'b0;
                  if (exp_q >= 10'sd255) begin
                     stage_result <= {sign, 8'hFF, 23'h0};
                     stage_ovf    <= 1'b1;
                     stage_unf    <= 1'b0;
                  end else if (exp_q <= 10'sd0) begin
                     stage_result <= {sign, 31'h0};
                     stage_ovf    <= 1'b0;
                     stage_unf    <= 1'b1;
                  end else begin
                     stage_result <= {sign, exp_q[7:0], mant_q};
                     stage_ovf    <= 1'b0;
                     stage_unf    <= 1'b0;
                  end
               end
               state <= DONE;
            end
            DONE: begin
               result_q <= stage_result;
               ovf_q    <= stage_ovf;
               unf_q    <= stage_unf;
               exc_q    <= stage_exc;
               done_q   <= 1'b1;
               count    <= '0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
